// File: rtl/mr_scoreboard.sv
// Register-hazard scoreboard between decode and ALU: per-register pending-write
// counters, an in-flight limit, and a combinational issue ready.
module mr_scoreboard #(
  parameter int CNT_BITS     = 2,
  parameter int MAX_INFLIGHT = 4,
  localparam int IW          = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [4:0]    id_rs1,
  input  logic [4:0]    id_rs2,
  input  logic          id_rs1_used,
  input  logic          id_rs2_used,
  input  logic [4:0]    id_rd,
  input  logic          id_rd_we,
  input  logic          alu_ready,
  output logic          id_ready,
  input  logic          wb_valid,
  input  logic [4:0]    wb_reg,
  input  logic          flush,
  output logic [31:0]   pending_mask,
  output logic [IW-1:0] inflight,
  output logic          busy,
  output logic          err_underflow
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [IW-1:0]       INF_MAX = IW'(MAX_INFLIGHT);

  logic [CNT_BITS-1:0] cnt_q [32];
  logic [CNT_BITS-1:0] cnt_d [32];
  logic [IW-1:0]       inflight_q, inflight_d;
  logic                err_q, err_d;

  logic raw1, raw2, sat, full, rd_counted;
  logic issue_cnt, retire_req, retire_ok;

  // Hazards look only at registered state, so a retire never bypasses into the same cycle.
  always_comb begin
    rd_counted = id_rd_we && (id_rd != 5'd0);
    raw1       = id_rs1_used && (id_rs1 != 5'd0) && (cnt_q[id_rs1] != '0);
    raw2       = id_rs2_used && (id_rs2 != 5'd0) && (cnt_q[id_rs2] != '0);
    sat        = rd_counted && (cnt_q[id_rd] == CNT_MAX);
    full       = rd_counted && (inflight_q == INF_MAX);
    id_ready   = alu_ready && !flush && !raw1 && !raw2 && !sat && !full;
    issue_cnt  = id_valid && id_ready && rd_counted;
    retire_req = wb_valid && (wb_reg != 5'd0) && !flush;
    retire_ok  = retire_req && (cnt_q[wb_reg] != '0);
  end

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    inflight_d = inflight_q;
    err_d      = err_q || (retire_req && !retire_ok);

    if (flush) begin
      for (int r = 0; r < 32; r++) begin
        cnt_d[r] = '0;
      end
      inflight_d = '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (issue_cnt && (id_rd == 5'(r)) && !(retire_ok && (wb_reg == 5'(r)))) begin
          cnt_d[r] = cnt_q[r] + CNT_BITS'(1);
        end else if (retire_ok && (wb_reg == 5'(r)) && !(issue_cnt && (id_rd == 5'(r)))) begin
          cnt_d[r] = cnt_q[r] - CNT_BITS'(1);
        end
      end
      case ({issue_cnt, retire_ok})
        2'b10:   inflight_d = inflight_q + IW'(1);
        2'b01:   inflight_d = inflight_q - IW'(1);
        default: inflight_d = inflight_q;
      endcase
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int r = 1; r < 32; r++) begin
      pending_mask[r] = (cnt_q[r] != '0);
    end
  end

  assign inflight      = inflight_q;
  assign busy          = (inflight_q != '0);
  assign err_underflow = err_q;

endmodule

// File: tb/tb_mr_scoreboard.sv
// Directed self-checking bench for mr_scoreboard: one task per scenario, inline compares.
module tb_mr_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_rs1_used, id_rs2_used, id_rd_we, alu_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_reg;
  logic        wb_valid, flush;
  logic        id_ready, busy, err_underflow;
  logic [31:0] pending_mask;
  logic [2:0]  inflight;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mr_scoreboard #(.CNT_BITS(2), .MAX_INFLIGHT(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .alu_ready(alu_ready), .id_ready(id_ready), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .flush(flush), .pending_mask(pending_mask), .inflight(inflight), .busy(busy),
    .err_underflow(err_underflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_we = 0; alu_ready = 1; wb_valid = 0; wb_reg = 0; flush = 0;
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    idle();
    id_valid = 1; id_rd = rd; id_rd_we = 1;
    #1;
  endtask

  task automatic retire(input logic [4:0] r);
    idle();
    wb_valid = 1; wb_reg = r;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #12;
    if (pending_mask !== 32'h0) begin n_fail++; $display("FAIL reset_pending got %h want %h", pending_mask, 32'h0); end
    n_checks++;
    if (inflight !== 3'd0) begin n_fail++; $display("FAIL reset_inflight got %0d want 0", inflight); end
    n_checks++;
    if (busy !== 1'b0 || err_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_busy_err got %b%b want 00", busy, err_underflow); end
    n_checks++;
    if (id_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_hi got %b want 1", id_ready); end
    n_checks++;
    alu_ready = 0;
    #1;
    if (id_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_lo got %b want 0", id_ready); end
    n_checks++;
    alu_ready = 1;
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_independent();
    for (int i = 1; i <= 3; i++) begin
      issue_wr(5'(i));
      if (id_ready !== 1'b1) begin n_fail++; $display("FAIL indep_ready[%0d] got %b want 1", i, id_ready); end
      n_checks++;
      tick();
      if (inflight !== 3'(i)) begin n_fail++; $display("FAIL indep_inflight[%0d] got %0d want %0d", i, inflight, i); end
      n_checks++;
    end
    idle();
    if (pending_mask !== 32'h0000_000E) begin n_fail++; $display("FAIL indep_pending got %h want %h", pending_mask, 32'hE); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL indep_busy got %b want 1", busy); end
    n_checks++;
    for (int i = 1; i <= 3; i++) begin
      retire(5'(i));
      tick();
    end
    idle();
    if (inflight !== 3'd0 || pending_mask !== 32'h0) begin n_fail++; $display("FAIL indep_drain got %0d/%h want 0/0", inflight, pending_mask); end
    n_checks++;
  endtask

  task automatic test_raw();
    issue_wr(5'd5);
    tick();
    idle();
    id_valid = 1; id_rs1 = 5; id_rs1_used = 1; id_rd = 6; id_rd_we = 1;
    #1;
    for (int c = 0; c < 2; c++) begin
      if (id_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall[%0d] got %b want 0", c, id_ready); end
      n_checks++;
      tick();
    end
    wb_valid = 1; wb_reg = 5;
    #1;
    if (id_ready !== 1'b0) begin n_fail++; $display("FAIL raw_no_bypass got %b want 0", id_ready); end
    n_checks++;
    tick();
    wb_valid = 0;
    #1;
    if (pending_mask[5] !== 1'b0) begin n_fail++; $display("FAIL raw_bit5 got %b want 0", pending_mask[5]); end
    n_checks++;
    if (id_ready !== 1'b1) begin n_fail++; $display("FAIL raw_resume got %b want 1", id_ready); end
    n_checks++;
    tick();
    idle();
    if (inflight !== 3'd1 || pending_mask !== 32'h0000_0040) begin n_fail++; $display("FAIL raw_issued got %0d/%h want 1/%h", inflight, pending_mask, 32'h40); end
    n_checks++;
    retire(5'd6);
    tick();
    idle();
  endtask

  task automatic test_x0();
    issue_wr(5'd0);
    id_rs1 = 0; id_rs1_used = 1;
    #1;
    if (id_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready got %b want 1", id_ready); end
    n_checks++;
    tick();
    idle();
    if (inflight !== 3'd0 || pending_mask !== 32'h0) begin n_fail++; $display("FAIL x0_state got %0d/%h want 0/0", inflight, pending_mask); end
    n_checks++;
    retire(5'd0);
    tick();
    idle();
    if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL x0_err got %b want 0", err_underflow); end
    n_checks++;
  endtask

  task automatic test_limits();
    for (int i = 0; i < 3; i++) begin
      issue_wr(5'd7);
      tick();
    end
    issue_wr(5'd7);
    if (id_ready !== 1'b0) begin n_fail++; $display("FAIL sat_stall got %b want 0", id_ready); end
    n_checks++;
    tick();
    if (inflight !== 3'd3) begin n_fail++; $display("FAIL sat_inflight got %0d want 3", inflight); end
    n_checks++;
    issue_wr(5'd1);
    if (id_ready !== 1'b1) begin n_fail++; $display("FAIL pre_full_ready got %b want 1", id_ready); end
    n_checks++;
    tick();
    issue_wr(5'd2);
    if (id_ready !== 1'b0) begin n_fail++; $display("FAIL full_stall got %b want 0", id_ready); end
    n_checks++;
    id_valid = 0; id_rd_we = 0;
    #1;
    if (id_ready !== 1'b1) begin n_fail++; $display("FAIL full_nowrite got %b want 1", id_ready); end
    n_checks++;
    id_valid = 1; id_rd_we = 1; wb_valid = 1; wb_reg = 7;
    #1;
    if (id_ready !== 1'b0) begin n_fail++; $display("FAIL full_same_cycle got %b want 0", id_ready); end
    n_checks++;
    tick();
    wb_valid = 0;
    #1;
    if (id_ready !== 1'b1) begin n_fail++; $display("FAIL full_resume got %b want 1", id_ready); end
    n_checks++;
    tick();
    idle();
    if (inflight !== 3'd4 || pending_mask !== 32'h0000_0086) begin n_fail++; $display("FAIL full_after got %0d/%h want 4/%h", inflight, pending_mask, 32'h86); end
    n_checks++;
    flush = 1;
    tick();
    idle();
    if (inflight !== 3'd0 || pending_mask !== 32'h0) begin n_fail++; $display("FAIL limits_flush got %0d/%h want 0/0", inflight, pending_mask); end
    n_checks++;
  endtask

  task automatic test_simultaneous();
    issue_wr(5'd9);
    tick();
    issue_wr(5'd9);
    wb_valid = 1; wb_reg = 9;
    #1;
    if (id_ready !== 1'b1) begin n_fail++; $display("FAIL simul_ready got %b want 1", id_ready); end
    n_checks++;
    tick();
    idle();
    if (inflight !== 3'd1 || pending_mask !== 32'h0000_0200) begin n_fail++; $display("FAIL simul_same got %0d/%h want 1/%h", inflight, pending_mask, 32'h200); end
    n_checks++;
    retire(5'd9);
    tick();
    idle();
    if (inflight !== 3'd0 || pending_mask !== 32'h0) begin n_fail++; $display("FAIL simul_clear got %0d/%h want 0/0", inflight, pending_mask); end
    n_checks++;
    issue_wr(5'd12);
    tick();
    issue_wr(5'd13);
    wb_valid = 1; wb_reg = 12;
    tick();
    idle();
    if (inflight !== 3'd1 || pending_mask !== 32'h0000_2000) begin n_fail++; $display("FAIL simul_diff got %0d/%h want 1/%h", inflight, pending_mask, 32'h2000); end
    n_checks++;
    retire(5'd13);
    tick();
    retire(5'd10);
    tick();
    idle();
    if (err_underflow !== 1'b1 || inflight !== 3'd0) begin n_fail++; $display("FAIL underflow got %b/%0d want 1/0", err_underflow, inflight); end
    n_checks++;
    tick();
    tick();
    if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky got %b want 1", err_underflow); end
    n_checks++;
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 3; i++) begin
      issue_wr(5'(i));
      tick();
    end
    issue_wr(5'd4);
    flush = 1; wb_valid = 1; wb_reg = 1;
    #1;
    if (id_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b want 0", id_ready); end
    n_checks++;
    tick();
    idle();
    if (inflight !== 3'd0 || pending_mask !== 32'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_state got %0d/%h/%b want 0/0/0", inflight, pending_mask, busy); end
    n_checks++;
    if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL flush_err_held got %b want 1", err_underflow); end
    n_checks++;
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 2; i++) begin
      issue_wr(5'(i + 20));
      tick();
    end
    idle();
    if (inflight !== 3'd2) begin n_fail++; $display("FAIL rstmid_pre got %0d want 2", inflight); end
    n_checks++;
    #2;
    rst_n = 0;
    #1;
    if (inflight !== 3'd0 || pending_mask !== 32'h0 || busy !== 1'b0 || err_underflow !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async got %0d/%h/%b/%b want 0/0/0/0", inflight, pending_mask, busy, err_underflow);
    end
    n_checks++;
    @(negedge clk);
    rst_n = 1;
    tick();
    issue_wr(5'd21);
    id_rs1 = 21; id_rs1_used = 1; id_rd_we = 0; id_valid = 0;
    #1;
    if (id_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b want 1", id_ready); end
    n_checks++;
    idle();
  endtask

  initial begin
    rst_n = 0;
    idle();
    test_reset();
    test_independent();
    test_raw();
    test_x0();
    test_limits();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mr_scoreboard.md
# mr_scoreboard

Register-hazard scoreboard and issue controller between decode and the ALU stage. It tracks outstanding register writes issued by decode and not yet retired by writeback. It holds decode with a combinational ready when a source operand would read a stale register-file value, a destination counter would saturate, or the in-flight limit is reached. Writeback retirements and pipeline flushes release the held state.

## Interface
Parameters:
- CNT_BITS, 2: width of each per-register pending-write counter; CNT_MAX = 2^CNT_BITS-1
- MAX_INFLIGHT, 4: maximum outstanding register writes across all registers

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  decode holds an instruction to issue
- id_rs1 / id_rs2  in  5 each  source register selects
- id_rs1_used / id_rs2_used  in  1 each  source actually read by the instruction
- id_rd  in  5  destination register
- id_rd_we  in  1  instruction writes id_rd
- alu_ready  in  1  downstream stage accepts an instruction
- id_ready  out  1  issue permitted this cycle (combinational)
- wb_valid  in  1  writeback retires one write this cycle
- wb_reg  in  5  register retired
- flush  in  1  discard all outstanding state
- pending_mask  out  32  bit r = 1 when counter[r] != 0 (registered); bit 0 always 0
- inflight  out  $clog2(MAX_INFLIGHT+1)  outstanding write count (registered)
- busy  out  1  inflight != 0
- err_underflow  out  1  sticky: retire of a register with counter 0

## Operation
- State: counter[1..31] (CNT_BITS each), inflight, err_underflow. x0 has no counter and is never pending.
- Hazard terms, all from registered state:
  - raw1 = id_rs1_used & rs1!=0 & counter[rs1]!=0
  - raw2 = the same test on rs2
  - sat = id_rd_we & rd!=0 & counter[rd]==CNT_MAX
  - full = id_rd_we & rd!=0 & inflight==MAX_INFLIGHT
- id_ready = alu_ready & !flush & !raw1 & !raw2 & !sat & !full. It does not depend on id_valid.
- issue = id_valid & id_ready. A counted issue (id_rd_we & rd!=0) increments counter[rd] and inflight.
- WAW is permitted. Up to CNT_MAX writes to one register may be outstanding, because the pipeline retires in order.
- retire = wb_valid & wb_reg!=0 & !flush. It decrements counter[wb_reg] and inflight.
- Retire with counter[wb_reg]==0: counters and inflight are left unchanged; err_underflow is set.
- wb_reg==0 is ignored silently.
- Counted issue and retire on the same register in the same cycle: that counter is unchanged, and inflight is unchanged.
- Issue and retire on different registers in the same cycle: each counter is updated independently; inflight is net unchanged.
- No bypass: a retire in cycle N does not clear a hazard in cycle N; the dependent instruction issues in N+1 at the earliest.
- flush: next state is all counters 0 and inflight 0. issue is impossible during flush because id_ready=0. wb_valid during flush is ignored. err_underflow is held.
- err_underflow clears only on reset.

## Timing
- Reset (rst_n low, asynchronous): all counters 0, inflight 0, pending_mask 0, busy 0, err_underflow 0. id_ready then equals alu_ready.
- All state updates on the rising clk edge following the issue/retire/flush cycle.
- pending_mask, inflight and busy reflect state after that edge.
- Reset asserted mid-operation discards all outstanding state immediately; there is no drain.
- Handshake: decode must hold id_* stable while id_valid & !id_ready. The transfer occurs in the cycle where both are high.
- The scoreboard has no register on the issue path: one-cycle throughput when no hazard.

## Test plan
- Independent stream: issue rd=x1, x2, x3 back-to-back with alu_ready=1 and no source use → id_ready=1 every cycle; inflight 1,2,3; pending_mask=0x0000000E.
- RAW stall: issue rd=x5, next instruction reads rs1=x5 → id_ready=0 until wb_valid/wb_reg=5 in cycle N; id_ready=1 in N+1, not in N; pending_mask bit5 clears after the edge.
- x0 handling: issue rd=x0 with id_rd_we=1, then read rs1=x0 → no stall, inflight stays 0; wb_reg=0 → err_underflow stays 0.
- Limits:
  - four writes to x7 with CNT_BITS=2 → 4th stalled on sat.
  - MAX_INFLIGHT=4 writes to x1..x4 → 5th stalled on full.
  - One retire of the limiting register → issue resumes next cycle.
- Simultaneous: counter[x9]=1, same cycle issue rd=x9 and retire x9 → counter[x9] stays 1, inflight unchanged. Retire x10 with counter 0 → err_underflow=1 and sticky.
- Flush/reset: 3 outstanding writes, assert flush with wb_valid=1 → id_ready=0 that cycle; next cycle inflight=0, pending_mask=0. Repeat with rst_n pulsed low mid-stream → outputs zero asynchronously.
